// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the parametrised UART.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clock_rate,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    function automatic bit div_legal(input int unsigned clock_rate,
                                     input int unsigned baud_rate,
                                     input int unsigned oversample);
        return calc_div(clock_rate, baud_rate, oversample) >= 1;
    endfunction

    function automatic bit oversample_legal(input int unsigned oversample);
        return (oversample >= 4) && ((oversample % 2) == 0);
    endfunction

    function automatic bit data_bits_legal(input int unsigned data_bits);
        return (data_bits >= 5) && (data_bits <= 9);
    endfunction

    function automatic bit stop_bits_legal(input int unsigned stop_bits);
        return (stop_bits == 1) || (stop_bits == 2);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (!div_legal(CLOCK_RATE, BAUD_RATE, OVERSAMPLE)) begin : g_bad_div
        $error("uart_tick_gen: CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) must be >= 1");
    end

    logic [CNT_W-1:0] cnt;

    // Divider counter; tick is registered so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART transceiver, LSB first, clock-enable driven.
// Define UART_PARITY_EN to add one even-parity bit after the data bits.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_err_frame,
    output logic                 rx_err_parity,
    output logic                 rx_busy,
    input  logic                 tx_en,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE * 2);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] OS_HALF   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    if (!oversample_legal(OVERSAMPLE)) begin : g_bad_os
        $error("uart_core: OVERSAMPLE must be even and >= 4");
    end
    if (!data_bits_legal(DATA_BITS)) begin : g_bad_db
        $error("uart_core: DATA_BITS must be 5..9");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_sb
        $error("uart_core: STOP_BITS must be 1 or 2");
    end

    logic tick;

    uart_tick_gen #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------------------------------------------------------- RX
    logic [1:0]           rx_sync;
    logic                 rx_s;
    logic                 rx_s_q;
    rx_state_t            rx_state, rx_state_d;
    logic [TICK_W-1:0]    rx_cnt, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d;
    logic                 rx_err_frame_d;

`ifdef UART_PARITY_EN
    logic rx_par_err, rx_par_err_d;
    logic rx_err_parity_d;
    logic tx_par;
`endif

    assign rx_s = rx_sync[1];

    // RX synchroniser, state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync      <= 2'b11;
            rx_s_q       <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_err_frame <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[0], rx};
            rx_s_q       <= rx_s;
            rx_state     <= rx_state_d;
            rx_cnt       <= rx_cnt_d;
            rx_idx       <= rx_idx_d;
            rx_shift     <= rx_shift_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            rx_err_frame <= rx_err_frame_d;
            rx_busy      <= (rx_state_d != RX_IDLE);
        end
    end

    // RX next state: mid-bit sampling counted in oversample ticks.
    always_comb begin
        rx_state_d     = rx_state;
        rx_cnt_d       = rx_cnt;
        rx_idx_d       = rx_idx;
        rx_shift_d     = rx_shift;
        rx_data_d      = rx_data;
        rx_valid_d     = 1'b0;
        rx_err_frame_d = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_err_d    = rx_par_err;
        rx_err_parity_d = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_en && rx_s_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt == OS_HALF) begin
                        rx_cnt_d   = '0;
                        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt + TICK_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_idx_d = '0;
`ifdef UART_PARITY_EN
                            rx_state_d = RX_PARITY;
`else
                            rx_state_d = RX_STOP;
`endif
                        end else begin
                            rx_idx_d = rx_idx + IDX_W'(1);
                        end
                    end else begin
                        rx_cnt_d = rx_cnt + TICK_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_d     = '0;
                        rx_par_err_d = rx_s ^ (^rx_shift);
                        rx_state_d   = RX_STOP;
                    end else begin
                        rx_cnt_d = rx_cnt + TICK_W'(1);
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RX_IDLE;
                        if (!rx_s) begin
                            rx_err_frame_d = 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else if (rx_par_err) begin
                            rx_err_parity_d = 1'b1;
                        end
`endif
                        else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_shift;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt + TICK_W'(1);
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state, tx_state_d;
    logic [TICK_W-1:0]    tx_cnt, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                 tx_line_d;
    logic                 tx_done_d;
    logic                 tx_accept;

    assign tx_accept = (tx_state == TX_IDLE) && tx_en && tx_start;

    // TX state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_idx   <= tx_idx_d;
            tx_shift <= tx_shift_d;
            tx       <= tx_line_d;
            tx_done  <= tx_done_d;
            tx_busy  <= (tx_state_d != TX_IDLE);
        end
    end

    // TX next state: each bit held OVERSAMPLE ticks, stop held STOP_BITS bits.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        tx_line_d  = tx;
        tx_done_d  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (tx_accept) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_DATA;
                        tx_line_d  = tx_shift[0];
                    end else begin
                        tx_cnt_d = tx_cnt + TICK_W'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_d = '0;
                        if (tx_idx == IDX_LAST) begin
                            tx_idx_d = '0;
`ifdef UART_PARITY_EN
                            tx_state_d = TX_PARITY;
                            tx_line_d  = tx_par;
`else
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
`endif
                        end else begin
                            tx_idx_d   = tx_idx + IDX_W'(1);
                            tx_shift_d = {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx_line_d  = tx_shift[1];
                        end
                    end else begin
                        tx_cnt_d = tx_cnt + TICK_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_cnt_d = tx_cnt + TICK_W'(1);
                    end
                end
            end
`endif
            TX_STOP: begin
                tx_line_d = 1'b1;
                if (tick) begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_cnt_d = tx_cnt + TICK_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    // Parity registers: RX mismatch flag, RX error pulse, TX parity of latched word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_par_err    <= 1'b0;
            rx_err_parity <= 1'b0;
            tx_par        <= 1'b0;
        end else begin
            rx_par_err    <= rx_par_err_d;
            rx_err_parity <= rx_err_parity_d;
            if (tx_accept) begin
                tx_par <= ^tx_data;
            end
        end
    end
`else
    assign rx_err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: random loopback traffic plus directed RX/TX corner cases.
module tb_uart_core;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int SB     = 1;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL         = 1 + DB + PB + SB;
    localparam int BIT_CLKS   = CLK_HZ / BAUD;
    localparam int FRAME_CLKS = FL * BIT_CLKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_en;
    logic          rx_line;
    logic          rx_valid;
    logic [DB-1:0] rx_data;
    logic          rx_err_frame;
    logic          rx_err_parity;
    logic          rx_busy;
    logic          tx_en;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic          tx;

    logic          rx_drv;
    bit            loop;

    always #5 clk = ~clk;

    assign rx_line = loop ? tx : rx_drv;

    uart_core #(
        .CLOCK_RATE (CLK_HZ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_en         (rx_en),
        .rx            (rx_line),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_err_frame  (rx_err_frame),
        .rx_err_parity (rx_err_parity),
        .rx_busy       (rx_busy),
        .tx_en         (tx_en),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx            (tx)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    flags;   // {valid, frame error, parity error}
        logic [DB-1:0] data;
    } rx_exp_t;

    rx_exp_t       rx_q[$];
    logic [FL-1:0] tx_q[$];
    logic [DB-1:0] last_good;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level frame: bit 0 is the start bit, then data LSB first, parity, stop bits.
    function automatic logic [FL-1:0] frame_bits(input logic [DB-1:0] d, input bit stop_low, input bit par_bad);
        logic [FL-1:0] f;
        int p;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1 + i] = d[i];
        p = 1 + DB;
        if (PB != 0) begin
            f[p] = (^d) ^ par_bad;
            p++;
        end
        if (stop_low) f[p] = 1'b0;
        return f;
    endfunction

    // TX monitor: detect start edge, sample every bit at its middle, compare with queued frame.
    logic          tx_prev = 1'b1;
    bit            mon_active = 1'b0;
    int            mon_cnt = 0;
    int            mon_k;
    logic [FL-1:0] mon_frame;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            mon_cnt++;
            if (mon_cnt >= BIT_CLKS / 2 && ((mon_cnt - BIT_CLKS / 2) % BIT_CLKS) == 0) begin
                mon_k = (mon_cnt - BIT_CLKS / 2) / BIT_CLKS;
                chk(tx == mon_frame[mon_k], "tx_bit", 32'(tx), 32'(mon_frame[mon_k]));
                if (mon_k == FL - 1) mon_active = 1'b0;
            end
        end else if (tx_prev && !tx) begin
            chk(tx_q.size() != 0, "tx_frame_expected", 32'(tx_q.size()), 1);
            if (tx_q.size() != 0) begin
                mon_frame  = tx_q.pop_front();
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end
        tx_prev = tx;
    end

    // RX monitor: every valid/error pulse must match the next expected event.
    rx_exp_t rx_cur;
    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_err_frame || rx_err_parity)) begin
            chk(rx_q.size() != 0, "rx_event_expected", 32'({rx_valid, rx_err_frame, rx_err_parity}), 0);
            if (rx_q.size() != 0) begin
                rx_cur = rx_q.pop_front();
                chk({rx_valid, rx_err_frame, rx_err_parity} == rx_cur.flags, "rx_event_kind",
                    32'({rx_valid, rx_err_frame, rx_err_parity}), 32'(rx_cur.flags));
                chk(rx_data == rx_cur.data, "rx_data", 32'(rx_data), 32'(rx_cur.data));
            end
        end
    end

    task automatic push_rx(input logic [2:0] flags, input logic [DB-1:0] d);
        rx_exp_t e;
        e.flags = flags;
        e.data  = d;
        rx_q.push_back(e);
    endtask

    // Drive a hand-built frame on rx; the expected RX outcome follows the framing rules.
    task automatic drive_rx(input logic [DB-1:0] d, input bit stop_low, input bit par_bad, input bit expect_evt);
        logic [FL-1:0] f;
        f = frame_bits(d, stop_low, par_bad);
        if (expect_evt) begin
            if (stop_low) push_rx(3'b010, last_good);
            else if (par_bad && PB != 0) push_rx(3'b001, last_good);
            else begin
                push_rx(3'b100, d);
                last_good = d;
            end
        end
        for (int i = 0; i < FL; i++) begin
            rx_drv = f[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    // Send one word on TX; optionally fire an extra tx_start mid-frame that must be ignored.
    task automatic send_tx(input logic [DB-1:0] d, input bit inject);
        int cyc;
        cyc = 0;
        while (tx_busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk(!tx_busy, "tx_idle_before_send", 32'(tx_busy), 0);
        tx_data  = d;
        tx_start = 1'b1;
        tx_q.push_back(frame_bits(d, 1'b0, 1'b0));
        if (loop) begin
            push_rx(3'b100, d);
            last_good = d;
        end
        @(negedge clk);
        tx_start = 1'b0;
        chk(tx_busy, "tx_busy_after_accept", 32'(tx_busy), 1);
        cyc = 0;
        while (!tx_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (inject) begin
                if (cyc == 50) begin
                    tx_data  = DB'(8'h77);
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
            end
        end
        tx_start = 1'b0;
        chk(cyc >= FRAME_CLKS - 1 && cyc <= FRAME_CLKS + 1, "tx_done_latency", 32'(cyc), 32'(FRAME_CLKS));
        chk(!tx_busy, "tx_busy_falls_with_done", 32'(tx_busy), 0);
        @(negedge clk);
        chk(!tx_done, "tx_done_single_pulse", 32'(tx_done), 0);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    int saw_done;

    initial begin
        rst      = 1'b1;
        rx_en    = 1'b1;
        tx_en    = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        rx_drv   = 1'b1;
        loop     = 1'b1;
        last_good = '0;
        repeat (5) @(negedge clk);

        // Reset state.
        chk(tx == 1'b1, "reset_tx", 32'(tx), 1);
        chk(rx_data == '0, "reset_rx_data", 32'(rx_data), 0);
        chk(!rx_valid, "reset_rx_valid", 32'(rx_valid), 0);
        chk(!rx_err_frame, "reset_rx_err_frame", 32'(rx_err_frame), 0);
        chk(!rx_err_parity, "reset_rx_err_parity", 32'(rx_err_parity), 0);
        chk(!rx_busy, "reset_rx_busy", 32'(rx_busy), 0);
        chk(!tx_busy, "reset_tx_busy", 32'(tx_busy), 0);
        chk(!tx_done, "reset_tx_done", 32'(tx_done), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // tx_en low blocks acceptance.
        tx_en    = 1'b0;
        tx_data  = DB'(8'h5A);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk(!tx_busy, "tx_en_gates_start", 32'(tx_busy), 0);
        tx_en = 1'b1;
        repeat (10) @(negedge clk);

        // Single frame, then back-to-back loopback words.
        send_tx(DB'(8'hA5), 1'b0);
        send_tx(DB'(8'h00), 1'b0);
        send_tx(DB'(8'hFF), 1'b0);
        send_tx(DB'(8'h3C), 1'b0);

        // Randomised loopback traffic with random idle gaps.
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_tx(DB'($urandom_range(0, (1 << DB) - 1)), 1'b0);
        end
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Framing error, then a good frame.
        loop = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        drive_rx(DB'(8'h55), 1'b1, 1'b0, 1'b1);
        chk(rx_data == last_good, "rx_data_kept_after_frame_err", 32'(rx_data), 32'(last_good));
        drive_rx(DB'(8'h12), 1'b0, 1'b0, 1'b1);

        // Start-bit glitch: short low pulse must be dropped silently.
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        chk(rx_busy, "glitch_enters_start", 32'(rx_busy), 1);
        repeat (10) @(negedge clk);
        chk(!rx_busy, "glitch_returns_idle", 32'(rx_busy), 0);
        repeat (2 * BIT_CLKS) @(negedge clk);

        // rx_en low blocks start detection.
        rx_en  = 1'b0;
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        chk(!rx_busy, "rx_en_gates_start", 32'(rx_busy), 0);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        rx_en = 1'b1;

`ifdef UART_PARITY_EN
        // Parity: generated bit checked by TX monitor; bad parity and frame precedence on RX.
        loop = 1'b1;
        send_tx(DB'(8'h07), 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        loop = 1'b0;
        drive_rx(DB'(8'h07), 1'b0, 1'b1, 1'b1);
        drive_rx(DB'(8'h07), 1'b1, 1'b1, 1'b1);
`endif

        // Extra tx_start during a frame is ignored.
        loop = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_tx(DB'(8'h11), 1'b1);
        repeat (FRAME_CLKS + 40) @(negedge clk);

        // Reset in the middle of data bit 3 aborts the frame.
        tx_data  = DB'(8'h11);
        tx_start = 1'b1;
        tx_q.push_back(frame_bits(DB'(8'h11), 1'b0, 1'b0));
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * BIT_CLKS + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        chk(tx == 1'b1, "rst_abort_tx", 32'(tx), 1);
        chk(!tx_busy, "rst_abort_tx_busy", 32'(tx_busy), 0);
        chk(!rx_busy, "rst_abort_rx_busy", 32'(rx_busy), 0);
        chk(rx_data == last_good, "rst_abort_rx_data", 32'(rx_data), 32'(last_good));
        saw_done = 0;
        for (int i = 0; i < FRAME_CLKS + 40; i++) begin
            @(negedge clk);
            if (tx_done) saw_done++;
        end
        chk(saw_done == 0, "rst_abort_no_tx_done", 32'(saw_done), 0);

        // Everything expected must have been observed.
        repeat (50) @(negedge clk);
        chk(rx_q.size() == 0, "rx_events_outstanding", 32'(rx_q.size()), 0);
        chk(tx_q.size() == 0, "tx_frames_outstanding", 32'(tx_q.size()), 0);
        chk(!mon_active, "tx_frame_incomplete", 32'(mon_active), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
